// File: rtl/pcpi_dispatch.sv
// pcpi_dispatch: registers one PCPI request, broadcasts it to NUM_CP coprocessors and returns one merged response or a timeout.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   pcpi_valid/insn/rs1/rs2        request from the core, held until response or timeout
//   pcpi_wr/rd/wait/ready/timeout  registered response to the core (ready/timeout are one-cycle pulses)
//   cp_valid/insn/rs1/rs2          latched request broadcast, stable while cp_valid=1
//   cp_wr/rd/wait/ready            per-coprocessor replies, index 0 has highest priority
module pcpi_dispatch #(
    parameter int NUM_CP  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pcpi_valid,
    input  logic [31:0]          pcpi_insn,
    input  logic [31:0]          pcpi_rs1,
    input  logic [31:0]          pcpi_rs2,
    output logic                 pcpi_wr,
    output logic [31:0]          pcpi_rd,
    output logic                 pcpi_wait,
    output logic                 pcpi_ready,
    output logic                 pcpi_timeout,
    output logic                 cp_valid,
    output logic [31:0]          cp_insn,
    output logic [31:0]          cp_rs1,
    output logic [31:0]          cp_rs2,
    input  logic [NUM_CP-1:0]    cp_wr,
    input  logic [32*NUM_CP-1:0] cp_rd,
    input  logic [NUM_CP-1:0]    cp_wait,
    input  logic [NUM_CP-1:0]    cp_ready
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   sel_rd;
    logic          sel_wr;
    // Walk from the highest index down so the lowest ready index is the one that sticks.
    always_comb begin
        sel_rd = '0;
        sel_wr = 1'b0;
        for (int i = NUM_CP - 1; i >= 0; i--) begin
            sel_rd = cp_ready[i] ? cp_rd[32*i +: 32] : sel_rd;
            sel_wr = cp_ready[i] ? cp_wr[i] : sel_wr;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pcpi_wr      <= 1'b0;
            pcpi_rd      <= '0;
            pcpi_wait    <= 1'b0;
            pcpi_ready   <= 1'b0;
            pcpi_timeout <= 1'b0;
            cp_valid     <= 1'b0;
            cp_insn      <= '0;
            cp_rs1       <= '0;
            cp_rs2       <= '0;
        end else begin
            // Response signals are pulses: cleared every cycle unless ISSUE sets them.
            pcpi_wr      <= 1'b0;
            pcpi_rd      <= '0;
            pcpi_wait    <= 1'b0;
            pcpi_ready   <= 1'b0;
            pcpi_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pcpi_valid) begin
                        cp_insn  <= pcpi_insn;
                        cp_rs1   <= pcpi_rs1;
                        cp_rs2   <= pcpi_rs2;
                        cp_valid <= 1'b1;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!pcpi_valid) begin
                        cp_valid <= 1'b0;
                        state    <= IDLE;
                    end else if (|cp_ready) begin
                        pcpi_rd    <= sel_rd;
                        pcpi_wr    <= sel_wr;
                        pcpi_ready <= 1'b1;
                        cp_valid   <= 1'b0;
                        state      <= RESP;
                    end else if (|cp_wait) begin
                        pcpi_wait <= 1'b1;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        pcpi_timeout <= 1'b1;
                        cp_valid     <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: state <= DRAIN;
                // Hold off until the core drops valid so the retiring instruction is not re-issued.
                DRAIN: state <= pcpi_valid ? DRAIN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_dispatch.sv
// tb_pcpi_dispatch: directed self-checking bench for pcpi_dispatch with NUM_CP=2, TIMEOUT=16.
module tb_pcpi_dispatch;
    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout, cp_valid;
    logic [31:0] pcpi_rd, cp_insn, cp_rs1, cp_rs2;
    logic [1:0]  cp_wr, cp_wait, cp_ready;
    logic [63:0] cp_rd;
    int n_chk = 0;
    int n_fail = 0;
    int seen;
    pcpi_dispatch #(.NUM_CP(2), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .pcpi_timeout(pcpi_timeout), .cp_valid(cp_valid), .cp_insn(cp_insn), .cp_rs1(cp_rs1),
        .cp_rs2(cp_rs2), .cp_wr(cp_wr), .cp_rd(cp_rd), .cp_wait(cp_wait), .cp_ready(cp_ready)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [132:0] all_out();
        return {pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout, cp_valid, cp_insn, cp_rs1, cp_rs2};
    endfunction
    task automatic cp_idle();
        cp_wr = 2'b00; cp_rd = '0; cp_wait = 2'b00; cp_ready = 2'b00;
    endtask
    initial begin
        reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        cp_idle();
        tick(); tick();
        chk("reset_outputs", all_out(), '0);
        reset = 1'b0;
        // 1: DIVU 100/7 answered by port 1
        pcpi_valid = 1'b1; pcpi_insn = 32'h0220_D0B3; pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7;
        tick();
        chk("div_cp_valid", cp_valid, 1);
        chk("div_cp_ops", {cp_insn, cp_rs1, cp_rs2}, {32'h0220_D0B3, 32'd100, 32'd7});
        chk("div_wait_early", pcpi_wait, 0);
        pcpi_rs1 = 32'd5; pcpi_rs2 = 32'd1;
        cp_wait = 2'b10;
        tick();
        chk("div_wait_1", {pcpi_wait, pcpi_ready}, 2'b10);
        tick();
        chk("div_wait_2", {pcpi_wait, pcpi_ready, cp_rs1, cp_rs2}, {2'b10, 32'd100, 32'd7});
        cp_wait = 2'b00; cp_ready = 2'b10; cp_wr = 2'b10;
        cp_rd = {cp_rs1 / cp_rs2, 32'h0};
        tick();
        chk("div_resp", {pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, cp_valid}, {2'b11, 32'd14, 2'b00});
        cp_idle();
        // 6: valid held 3 cycles past the response, no re-issue
        tick();
        chk("resp_clear", {pcpi_ready, pcpi_wr, pcpi_rd}, '0);
        tick();
        chk("drain_hold_1", {cp_valid, pcpi_ready}, 2'b00);
        tick();
        chk("drain_hold_2", {cp_valid, pcpi_ready}, 2'b00);
        pcpi_valid = 1'b0;
        tick();
        chk("drain_exit", cp_valid, 0);
        pcpi_valid = 1'b1; pcpi_insn = 32'h0000_1234; pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd3;
        tick();
        chk("reissue", {cp_valid, cp_insn, cp_rs1}, {1'b1, 32'h0000_1234, 32'd9});
        // abort: valid dropped mid-ISSUE, late ready ignored
        pcpi_valid = 1'b0;
        tick();
        chk("abort", {cp_valid, pcpi_ready, pcpi_wait}, 3'b000);
        cp_ready = 2'b01; cp_wr = 2'b01; cp_rd = {32'h0, 32'hDEAD_BEEF};
        tick();
        chk("abort_late_ready", {pcpi_ready, pcpi_rd, cp_valid}, '0);
        cp_idle();
        // 2: unclaimed instruction times out 16 cycles after cp_valid rises
        pcpi_valid = 1'b1; pcpi_insn = 32'h0000_000B;
        tick();
        chk("to_issue", cp_valid, 1);
        seen = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            seen += int'(pcpi_timeout) + int'(pcpi_ready) + int'(!cp_valid);
        end
        chk("to_not_early", seen, 0);
        tick();
        chk("to_pulse", {pcpi_timeout, pcpi_ready, cp_valid}, 3'b100);
        tick();
        chk("to_pulse_end", {pcpi_timeout, pcpi_ready, cp_valid}, 3'b000);
        pcpi_valid = 1'b0;
        tick();
        // 3: simultaneous ready, lowest index wins
        pcpi_valid = 1'b1; pcpi_insn = 32'h0000_0033;
        tick();
        cp_ready = 2'b11; cp_wr = 2'b11; cp_rd = {32'h22, 32'h11};
        tick();
        chk("prio_resp", {pcpi_ready, pcpi_wr, pcpi_rd}, {2'b11, 32'h11});
        cp_idle();
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen += int'(pcpi_ready);
        end
        chk("prio_single_pulse", seen, 0);
        pcpi_valid = 1'b0;
        tick();
        // 4: long claim never times out
        pcpi_valid = 1'b1;
        tick();
        cp_wait = 2'b01;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen += int'(pcpi_timeout) + int'(!pcpi_wait) + int'(!cp_valid);
        end
        chk("long_wait", seen, 0);
        cp_wait = 2'b00; cp_ready = 2'b01; cp_wr = 2'b01; cp_rd = {32'h0, 32'hFFFF_FFFF};
        tick();
        chk("long_resp", {pcpi_ready, pcpi_wr, pcpi_rd, pcpi_timeout}, {2'b11, 32'hFFFF_FFFF, 1'b0});
        cp_idle();
        pcpi_valid = 1'b0;
        tick(); tick();
        // 5: reset mid-ISSUE with a busy coprocessor
        pcpi_valid = 1'b1; pcpi_insn = 32'hABCD_0001; pcpi_rs1 = 32'h55; pcpi_rs2 = 32'h66;
        tick();
        cp_wait = 2'b01;
        tick();
        chk("rst_pre_wait", pcpi_wait, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_issue", all_out(), '0);
        reset = 1'b0; pcpi_valid = 1'b0;
        cp_wait = 2'b00; cp_ready = 2'b01; cp_wr = 2'b01; cp_rd = {32'h0, 32'h1234};
        tick();
        chk("rst_late_ready", {pcpi_ready, pcpi_rd, cp_valid}, '0);
        cp_idle();
        tick();
        chk("rst_idle", all_out(), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
